block_temporal_filter: RTL and testbench

- Downstream consumer of the block-mean stage. Takes the per-block 8-bit backlight levels (40 per block row, 20 rows, 800 per frame) and applies a first-order temporal IIR against the previous frame's value for the same block, which suppresses backlight flicker.
- Filtered values go into an output FIFO, tagged with a block address, for the LED-driver/SPI stage over a valid/ready handshake.

---
 rtl/block_temporal_filter.sv | 173 +++++++++++++++++
 tb/tb_block_temporal_filter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/block_temporal_filter.sv
// block_temporal_filter: first-order temporal IIR on per-block backlight levels.
// Each 8-bit block mean is blended with the same block's value from the previous
// frame (history RAM). Results are queued in a first-word-fall-through FIFO with
// their block address for the LED-driver stage.
// Optional feature: define BLOCK_TEMPORAL_FILTER_SCENE_CUT_EN so that a large
// frame-to-frame change (|d| >= SCENE_THRESH) bypasses the IIR.
module block_temporal_filter #(
  parameter int BLOCKS_X     = 40,
  parameter int BLOCKS_Y     = 20,
  parameter int ALPHA_SHIFT  = 2,
  parameter int FIFO_DEPTH   = 64,
  parameter int SCENE_THRESH = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs,
  input  logic [7:0] mean_in,
  input  logic       mean_valid,
  output logic [7:0] out_data,
  output logic [9:0] out_addr,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int         NUM_BLOCKS = BLOCKS_X * BLOCKS_Y;
  localparam int         PW         = $clog2(FIFO_DEPTH);
  localparam logic [9:0] NUM_IDX    = 10'(NUM_BLOCKS);
  localparam logic [9:0] LAST_IDX   = 10'(NUM_BLOCKS - 1);
  localparam logic [8:0] SNAP_LIM   = 9'(1 << ALPHA_SHIFT);
  localparam logic [8:0] SCENE_LIM  = 9'(SCENE_THRESH);
`ifdef BLOCK_TEMPORAL_FILTER_SCENE_CUT_EN
  localparam bit         SCENE_CUT  = 1'b1;
`else
  localparam bit         SCENE_CUT  = 1'b0;
`endif

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       last;
  } entry_t;

  // Control state
  state_t     state_q;
  logic       vs_q;
  logic [9:0] idx_q;
  logic       frame_err_q;
  logic       overflow_q;
  logic       vs_rise;
  logic [9:0] idx_eff;
  logic       accept;

  // Pipeline state
  logic       s1_valid_q;
  logic [9:0] s1_idx_q;
  logic [7:0] s1_mean_q;
  logic       s1_run_q;
  logic [7:0] prev_q;
  logic       s2_valid_q;
  entry_t     s2_entry_q;

  // History RAM and output FIFO
  logic [7:0] hist_mem [NUM_BLOCKS];
  entry_t     fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic       fifo_empty, fifo_full, pop, push_ok, drop;
  entry_t     head;

  // Filter arithmetic
  logic signed [8:0] diff;
  logic signed [8:0] step;
  logic        [8:0] abs_d;
  logic signed [9:0] sum;
  logic        [7:0] y;

  // Frame-start detect and effective write index (a vs_rise sample is index 0)
  always_comb begin
    // NOTE: always_comb assigns every output first so no path can infer a latch.
    vs_rise = vs & ~vs_q;
    idx_eff = vs_rise ? 10'd0 : idx_q;
    accept  = mean_valid && (idx_eff != NUM_IDX);
  end

  // FSM, write index, frame error and pipeline valids
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_INIT;
      vs_q        <= 1'b0;
      idx_q       <= 10'd0;
      frame_err_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
    end else begin
      vs_q        <= vs;
      frame_err_q <= vs_rise && (idx_q != 10'd0) && (idx_q != NUM_IDX);
      idx_q       <= accept ? idx_eff + 10'd1 : idx_eff;
      if (state_q == ST_INIT && accept && idx_eff == LAST_IDX) state_q <= ST_RUN;
      s1_valid_q  <= accept;
      s2_valid_q  <= s1_valid_q;
    end
  end

  // Datapath stage registers; the mode travels with each sample
  always_ff @(posedge clk) begin
    s1_idx_q   <= idx_eff;
    s1_mean_q  <= mean_in;
    s1_run_q   <= (state_q == ST_RUN);
    s2_entry_q <= '{addr: s1_idx_q, data: y, last: (s1_idx_q == LAST_IDX)};
  end

  // History RAM: registered read at the sample's index, write two cycles later
  always_ff @(posedge clk) begin
    // NOTE: memory arrays carry no reset; their contents are don't-care until written.
    if (s2_valid_q) hist_mem[s2_entry_q.addr] <= s2_entry_q.data;
    prev_q <= hist_mem[idx_eff];
  end

  // IIR with snap-to-input on small differences and optional scene cut
  always_comb begin
    diff  = $signed({1'b0, s1_mean_q}) - $signed({1'b0, prev_q});
    step  = diff >>> ALPHA_SHIFT;
    abs_d = diff[8] ? 9'(-diff) : 9'(diff);
    sum   = $signed({2'b00, prev_q}) + $signed({step[8], step});
    y     = sum[7:0];
    if (!s1_run_q || abs_d < SNAP_LIM) y = s1_mean_q;
    else if (SCENE_CUT && abs_d >= SCENE_LIM) y = s1_mean_q;
  end

  // FIFO flags; a pop in the same cycle frees the slot for a push
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    pop        = !fifo_empty && out_ready;
    push_ok    = s2_valid_q && (!fifo_full || pop);
    drop       = s2_valid_q && fifo_full && !pop;
    head       = fifo_mem[rd_ptr_q[PW-1:0]];
  end

  // FIFO pointers and sticky overflow (a drop outranks the frame-start clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop)         overflow_q <= 1'b1;
      else if (vs_rise) overflow_q <= 1'b0;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[PW-1:0]] <= s2_entry_q;
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 8'd0  : head.data;
  assign out_addr  = fifo_empty ? 10'd0 : head.addr;
  assign out_last  = !fifo_empty && head.last;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_block_temporal_filter.sv
// Directed bench for block_temporal_filter (ALPHA_SHIFT=2, FIFO_DEPTH=32,
// scene cut disabled). Expected levels are hand-computed per frame.
module tb_block_temporal_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs;
  logic [7:0] mean_in;
  logic       mean_valid;
  logic [7:0] out_data;
  logic [9:0] out_addr;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       frame_err;

  logic [7:0] din  [800];
  logic [7:0] dexp [800];
  int n_checks = 0;
  int n_err    = 0;

  block_temporal_filter #(.FIFO_DEPTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .vs        (vs),
    .mean_in   (mean_in),
    .mean_valid(mean_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] dv, input logic [7:0] ev);
    for (int i = 0; i < 800; i++) begin
      din[i]  = dv;
      dexp[i] = ev;
    end
  endtask

  // Start a frame with vs rising on the first sample, stream n samples with
  // out_ready high, and check every output entry as it appears.
  task automatic run_frame(input int n, input logic exp_err);
    int exp_addr;
    int first_valid;
    exp_addr    = 0;
    first_valid = -1;
    out_ready   = 1'b1;
    vs          = 1'b1;
    mean_valid  = 1'b1;
    mean_in     = din[0];
    for (int cyc = 1; cyc <= n + 6; cyc++) begin
      tick();
      if (cyc == 1) begin
        chk("frame_err_pulse", 32'(frame_err), 32'(exp_err));
        chk("overflow_clear", 32'(overflow), 32'd0);
      end
      if (cyc == 2) chk("frame_err_one_cycle", 32'(frame_err), 32'd0);
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        chk("out_addr", 32'(out_addr), 32'(exp_addr));
        chk("out_data", 32'(out_data), 32'(dexp[exp_addr % 800]));
        chk("out_last", 32'(out_last), 32'(exp_addr == 799));
        exp_addr++;
      end
      if (cyc < n) begin
        mean_valid = 1'b1;
        mean_in    = din[cyc];
      end else begin
        mean_valid = 1'b0;
        mean_in    = 8'd0;
      end
    end
    vs = 1'b0;
    chk("out_count", 32'(exp_addr), 32'(n));
    chk("first_valid_latency", 32'(first_valid), 32'd3);
    tick();
  endtask

  task automatic set_prev_blocks();
    din[0] = 8'd102; dexp[0] = 8'd102;
    din[1] = 8'd101; dexp[1] = 8'd101;
    din[2] = 8'd125; dexp[2] = 8'd125;
    din[3] = 8'd57;  dexp[3] = 8'd57;
  endtask

  initial begin
    rst        = 1'b1;
    vs         = 1'b0;
    mean_in    = 8'd0;
    mean_valid = 1'b0;
    out_ready  = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_addr",  32'(out_addr),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    tick();

    // Partial first frame of 500 zeros: outputs pass through in INIT
    fill(8'd0, 8'd0);
    run_frame(500, 1'b0);

    // Frame 1 all 200: frame_err for the short frame, still INIT so y = mean
    fill(8'd200, 8'd200);
    run_frame(800, 1'b1);

    // Frame 2 all 0: 200 + (-200 >>> 2) = 150
    fill(8'd0, 8'd150);
    run_frame(800, 1'b0);

    // Frame 3 all 0: 150 + (-150 >>> 2) = 150 - 38 = 112
    fill(8'd0, 8'd112);
    run_frame(800, 1'b0);

    // Frame 4: 300 zeros, 112 - 28 = 84, then reset mid-frame
    fill(8'd0, 8'd84);
    run_frame(300, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_overflow",  32'(overflow),  32'd0);
    rst = 1'b0;
    tick();

    // Frame 5 after reset is treated as the first frame: y = mean
    fill(8'd100, 8'd100);
    din[3] = 8'd10; dexp[3] = 8'd10;
    run_frame(800, 1'b0);

    // Frame 6: snap 100->102, step 100->104 gives 101, 100->200 gives 125,
    // 10->200 gives 57 with scene cut disabled
    fill(8'd100, 8'd100);
    din[0] = 8'd102; dexp[0] = 8'd102;
    din[1] = 8'd104; dexp[1] = 8'd101;
    din[2] = 8'd200; dexp[2] = 8'd125;
    din[3] = 8'd200; dexp[3] = 8'd57;
    run_frame(800, 1'b0);

    // Frame 7: 40-sample burst with out_ready low; blocks 32..39 go 100->180 (y=120)
    fill(8'd100, 8'd100);
    set_prev_blocks();
    for (int i = 32; i < 40; i++) begin
      din[i]  = 8'd180;
      dexp[i] = 8'd120;
    end
    out_ready  = 1'b0;
    vs         = 1'b1;
    mean_valid = 1'b1;
    mean_in    = din[0];
    for (int i = 1; i < 40; i++) begin
      tick();
      mean_in = din[i];
    end
    tick();
    mean_valid = 1'b0;
    repeat (4) tick();
    chk("burst_overflow",  32'(overflow),  32'd1);
    chk("burst_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      chk("burst_addr", 32'(out_addr), 32'(k));
      chk("burst_data", 32'(out_data), 32'(dexp[k]));
      tick();
    end
    chk("burst_drained", 32'(out_valid), 32'd0);
    chk("burst_overflow_sticky", 32'(overflow), 32'd1);
    vs = 1'b0;
    tick();

    // Frame 8: dropped blocks 32..39 must still have history 120 (no change)
    fill(8'd100, 8'd100);
    set_prev_blocks();
    for (int i = 32; i < 40; i++) begin
      din[i]  = 8'd120;
      dexp[i] = 8'd120;
    end
    run_frame(40, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
